decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 47 ++++
 rtl/decoder_table.sv | 37 +++
 rtl/decoder.sv | 75 +++++++
 tb/tb_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared decode configuration: instruction geometry, field positions and the opcode map.
`ifndef DECODER_PKG_SV
`define DECODER_PKG_SV
`define WORD 32

package decoder_pkg;

  localparam int unsigned CFG_WORD_W = `WORD;
  localparam int unsigned CFG_OPC_W  = 6;
  localparam int unsigned CFG_REG_W  = 5;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS_LSB  = 16;

  localparam logic [5:0] OP_NOP       = 6'h00;
  localparam logic [5:0] OP_ADD       = 6'h01;
  localparam logic [5:0] OP_INT_LAST  = 6'h1F;
  localparam logic [5:0] OP_FADD      = 6'h20;
  localparam logic [5:0] OP_FALU_LAST = 6'h2E;
  localparam logic [5:0] OP_FCMP      = 6'h2F;
  localparam logic [5:0] OP_LOAD      = 6'h30;
  localparam logic [5:0] OP_STORE     = 6'h31;
  localparam logic [5:0] OP_FLOAD     = 6'h32;
  localparam logic [5:0] OP_FSTORE    = 6'h33;
  localparam logic [5:0] OP_BR_FIRST  = 6'h38;
  localparam logic [5:0] OP_BR_LAST   = 6'h3B;
  localparam logic [5:0] OP_JAL       = 6'h3C;

  // Illegal opcode list: two contiguous holes in the map.
  localparam logic [5:0] ILL_A_FIRST = 6'h34;
  localparam logic [5:0] ILL_A_LAST  = 6'h37;
  localparam logic [5:0] ILL_B_FIRST = 6'h3D;

  typedef struct packed {
    logic legal;
    logic isfloat;
    logic iswrite;
  } dec_attr_t;

  function automatic logic is_illegal_opc(input logic [5:0] op);
    return ((op >= ILL_A_FIRST) && (op <= ILL_A_LAST)) || (op >= ILL_B_FIRST);
  endfunction

endpackage

`endif

// File: rtl/decoder_table.sv
// Combinational opcode classifier: opcode -> {legal, isfloat, iswrite}.
module decoder_table
  import decoder_pkg::*;
#(
  parameter int unsigned OPC_W = CFG_OPC_W
) (
  input  logic [OPC_W-1:0] i_opc,
  output dec_attr_t        o_attr_c
);

  always_comb begin
    o_attr_c.legal   = ~is_illegal_opc(6'(i_opc));
    o_attr_c.isfloat = 1'b0;
    o_attr_c.iswrite = 1'b0;
    if (i_opc == OPC_W'(OP_NOP)) begin
      o_attr_c.iswrite = 1'b0;
    end else if (i_opc <= OPC_W'(OP_INT_LAST)) begin
      o_attr_c.iswrite = 1'b1;
    end else if (i_opc <= OPC_W'(OP_FALU_LAST)) begin
      o_attr_c.isfloat = 1'b1;
      o_attr_c.iswrite = 1'b1;
    end else if (i_opc == OPC_W'(OP_FCMP)) begin
      o_attr_c.isfloat = 1'b1;
    end else if (i_opc == OPC_W'(OP_LOAD)) begin
      o_attr_c.iswrite = 1'b1;
    end else if (i_opc == OPC_W'(OP_FLOAD)) begin
      o_attr_c.isfloat = 1'b1;
      o_attr_c.iswrite = 1'b1;
    end else if (i_opc == OPC_W'(OP_FSTORE)) begin
      o_attr_c.isfloat = 1'b1;
    end else if (i_opc == OPC_W'(OP_JAL)) begin
      o_attr_c.iswrite = 1'b1;
    end
    // STORE and branches keep the all-zero attributes.
  end

endmodule

// File: rtl/decoder.sv
// Instruction decoder: field extraction, integer-r0 write suppression and output registers.
module decoder
  import decoder_pkg::*;
#(
  parameter int unsigned WORD_W = CFG_WORD_W,
  parameter int unsigned OPC_W  = CFG_OPC_W,
  parameter int unsigned REG_W  = CFG_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] inst,
  output logic [OPC_W-1:0]  opc,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rs,
  output logic              isfloat,
  output logic              iswrite
);

  logic [OPC_W-1:0] w_opc;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_rs;
  logic             w_iswrite;
  logic             w_unused;
  dec_attr_t        w_attr;

  logic [OPC_W-1:0] r_opc;
  logic [REG_W-1:0] r_rd;
  logic [REG_W-1:0] r_rs;
  logic             r_isfloat;
  logic             r_iswrite;

  assign w_opc    = inst[OPC_LSB +: OPC_W];
  assign w_rd     = inst[RD_LSB +: REG_W];
  assign w_rs     = inst[RS_LSB +: REG_W];
  assign w_unused = ^inst[RS_LSB-1:0];

  decoder_table #(
    .OPC_W (OPC_W)
  ) u_table (
    .i_opc    (w_opc),
    .o_attr_c (w_attr)
  );

  // Integer r0 is hardwired to zero, so writes to it are dropped; f0 is an ordinary register.
  assign w_iswrite = w_attr.iswrite & (w_attr.isfloat | (w_rd != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opc     <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_isfloat <= 1'b0;
      r_iswrite <= 1'b0;
    end else if (!w_attr.legal) begin
      r_opc     <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_isfloat <= 1'b0;
      r_iswrite <= 1'b0;
    end else begin
      r_opc     <= w_opc;
      r_rd      <= w_rd;
      r_rs      <= w_rs;
      r_isfloat <= w_attr.isfloat;
      r_iswrite <= w_iswrite;
    end
  end

  assign opc     = r_opc;
  assign rd      = r_rd;
  assign rs      = r_rs;
  assign isfloat = r_isfloat;
  assign iswrite = r_iswrite;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: vector table through a scoreboard queue, plus reset sequences.
module tb_decoder;

  typedef struct packed {
    logic [5:0] opc;
    logic [4:0] rd;
    logic [4:0] rs;
    logic       fl;
    logic       wr;
  } out_t;

  typedef struct {
    logic [31:0] inst;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [5:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic        isfloat;
  logic        iswrite;

  int errors = 0;
  int checks = 0;

  out_t exp_q[$];
  vec_t vecs[$];

  decoder #(
    .WORD_W (32),
    .OPC_W  (6),
    .REG_W  (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .opc     (opc),
    .rd      (rd),
    .rs      (rs),
    .isfloat (isfloat),
    .iswrite (iswrite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic out_t got();
    out_t o;
    o.opc = opc; o.rd = rd; o.rs = rs; o.fl = isfloat; o.wr = iswrite;
    return o;
  endfunction

  function automatic out_t mk(input int o, input int d, input int s, input bit f, input bit w);
    out_t r;
    r.opc = 6'(o); r.rd = 5'(d); r.rs = 5'(s); r.fl = f; r.wr = w;
    return r;
  endfunction

  // Independent reference decode, written from the opcode map.
  function automatic out_t model(input logic [31:0] w);
    int  op;
    int  d;
    int  s;
    bit  f;
    bit  wr;
    bit  ok;
    op = int'(w[31:26]); d = int'(w[25:21]); s = int'(w[20:16]);
    f = 0; wr = 0; ok = 1;
    if (op >= 1 && op <= 31)       wr = 1;
    else if (op >= 32 && op <= 46) begin f = 1; wr = 1; end
    else if (op == 47)             f = 1;
    else if (op == 48)             wr = 1;
    else if (op == 50)             begin f = 1; wr = 1; end
    else if (op == 51)             f = 1;
    else if (op == 60)             wr = 1;
    else if (op == 0 || op == 49 || (op >= 56 && op <= 59)) ok = 1;
    else                           ok = 0;
    if (!f && d == 0) wr = 0;
    if (!ok) return mk(0, 0, 0, 0, 0);
    return mk(op, d, s, f, wr);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got opc=%h rd=%0d rs=%0d isfloat=%b iswrite=%b, want opc=%h rd=%0d rs=%0d isfloat=%b iswrite=%b",
               name, act.opc, act.rd, act.rs, act.fl, act.wr, exp.opc, exp.rd, exp.rs, exp.fl, exp.wr);
    end
  endtask

  task automatic add(input logic [31:0] i, input out_t e);
    vec_t v;
    v.inst = i; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    out_t zero;
    out_t e;
    zero = mk(0, 0, 0, 0, 0);

    add(32'h04640000, mk(8'h01, 3, 4, 0, 1));
    add(32'h80220000, mk(8'h20, 1, 2, 1, 1));
    add(32'hC4A60000, mk(8'h31, 5, 6, 0, 0));
    add(32'h04000000, mk(8'h01, 0, 0, 0, 0));
    add(32'hFC000000, zero);
    add(32'hBC430000, mk(8'h2F, 2, 3, 1, 0));
    add(32'h80070000, mk(8'h20, 0, 7, 1, 1));
    add(32'hC1210000, mk(8'h30, 9, 1, 0, 1));
    add(32'hC0000000, mk(8'h30, 0, 0, 0, 0));
    add(32'hC8040000, mk(8'h32, 0, 4, 1, 1));
    add(32'hCC210000, mk(8'h33, 1, 1, 1, 0));
    add(32'hE0620000, mk(8'h38, 3, 2, 0, 0));
    add(32'hEFFFABCD, mk(8'h3B, 31, 31, 0, 0));
    add(32'hF3E00000, mk(8'h3C, 31, 0, 0, 1));
    add(32'hF0000000, mk(8'h3C, 0, 0, 0, 0));
    add(32'hD0A60000, zero);
    add(32'hDFFF1234, zero);
    add(32'hF4210000, zero);
    add(32'h00A60000, mk(8'h00, 5, 6, 0, 0));
    add(32'h7C200000, mk(8'h1F, 1, 0, 0, 1));
    add(32'hB8000000, mk(8'h2E, 0, 0, 1, 1));
    for (int k = 0; k < 150; k++) begin
      logic [31:0] r;
      r = $urandom;
      add(r, model(r));
    end

    // Outputs held at zero throughout reset, regardless of clock or inst.
    rst  = 1'b0;
    inst = 32'h04640000;
    #3;
    check("reset_async", got(), zero);
    @(posedge clk); @(posedge clk); #1;
    check("reset_state", got(), zero);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_release_hold", got(), zero);

    // Scoreboard: expectation queued at drive, compared one cycle later.
    foreach (vecs[k]) begin
      @(negedge clk);
      if (exp_q.size() != 0) check($sformatf("vec%0d", k - 1), got(), exp_q.pop_front());
      inst = vecs[k].inst;
      exp_q.push_back(vecs[k].exp);
    end
    @(negedge clk);
    if (exp_q.size() != 0) check("vec_last", got(), exp_q.pop_front());

    // Mid-stream reset clears immediately and drops the decode in flight.
    @(negedge clk);
    inst = 32'h04640000;
    @(posedge clk); #1;
    check("pre_reset", got(), mk(8'h01, 3, 4, 0, 1));
    #1;
    inst = 32'h80220000;
    rst  = 1'b0;
    #1;
    check("midreset_async", got(), zero);
    @(posedge clk); #1;
    check("midreset_hold", got(), zero);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_release", got(), zero);
    @(posedge clk); #1;
    check("first_after_release", got(), mk(8'h20, 1, 2, 1, 1));
    e = model(32'h80220000);
    check("first_after_release_model", got(), e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
